// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic matrix-multiply datapath: sequencer
// state encoding and default array geometry.
package tpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  localparam int DEFAULT_N        = 2;
  localparam int DEFAULT_OP_WIDTH = 8;

endpackage

// File: rtl/skew_line.sv
// Per-lane delay line: delays an operand by DEPTH cycles and outputs zero
// whenever the slot it presents holds no valid element.
module skew_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    // Buffer read data is already registered; lane 0 only needs gating.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign out_data = in_valid ? in_data : '0;
  end else begin : g_shift
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
        // NOTE: these data stages are a short shift register, not a RAM, so
        // clearing them on reset is cheap and keeps the lanes at zero.
        for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
      end else begin
        valid_q[0] <= in_valid;
        data_q[0]  <= in_data;
        for (int s = 1; s < DEPTH; s++) begin
          valid_q[s] <= valid_q[s-1];
          data_q[s]  <= data_q[s-1];
        end
      end
    end

    assign out_data = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Runs one output-stationary matrix-multiply pass: clear, feed K skewed
// operand vectors, drain the array, then pulse done.
module systolic_sequencer
  import tpu_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int OP_WIDTH = DEFAULT_OP_WIDTH,
  parameter int K_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [K_WIDTH-1:0]    rd_addr,
  input  logic [N*OP_WIDTH-1:0] a_rd_data,
  input  logic [N*OP_WIDTH-1:0] b_rd_data,
  output logic                  mac_clear,
  output logic                  mac_ena,
  output logic [N*OP_WIDTH-1:0] new_a_column,
  output logic [N*OP_WIDTH-1:0] new_b_row
);

  // Drain covers the widest skew (N-1) plus the array's own N-1 hops.
  localparam int DRAIN_LEN = 2 * N - 1;
  localparam int DW        = $clog2(2 * N);

  seq_state_t         state, next_state;
  logic [K_WIDTH-1:0] k_len_q;
  logic [K_WIDTH-1:0] addr_q;
  logic [DW-1:0]      drain_q;
  logic               rd_valid_q;
  logic               last_feed;

  assign last_feed = (addr_q == k_len_q - K_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      k_len_q    <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= next_state;
      rd_valid_q <= (state == S_FEED);
      if (state == S_IDLE && start) k_len_q <= k_len;
      // Address stops at K-1 so it never wraps, even for the largest K.
      if (state == S_CLEAR) addr_q <= '0;
      else if (state == S_FEED && !last_feed) addr_q <= addr_q + K_WIDTH'(1);
      if (state == S_FEED) drain_q <= DW'(DRAIN_LEN - 1);
      else if (state == S_DRAIN) drain_q <= drain_q - DW'(1);
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the case statement can infer a latch.
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    mac_clear  = 1'b0;
    mac_ena    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) next_state = S_CLEAR;
      end
      S_CLEAR: begin
        mac_clear  = 1'b1;
        next_state = (k_len_q == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
        mac_ena = 1'b1;
        if (last_feed) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        mac_ena = 1'b1;
        if (drain_q == '0) next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(i), .WIDTH(OP_WIDTH)) u_skew_a (
      .clk      (clk),
      .reset    (reset),
      .in_valid (rd_valid_q),
      .in_data  (a_rd_data[i*OP_WIDTH +: OP_WIDTH]),
      .out_data (new_a_column[i*OP_WIDTH +: OP_WIDTH])
    );
    skew_line #(.DEPTH(i), .WIDTH(OP_WIDTH)) u_skew_b (
      .clk      (clk),
      .reset    (reset),
      .in_valid (rd_valid_q),
      .in_data  (b_rd_data[i*OP_WIDTH +: OP_WIDTH]),
      .out_data (new_b_row[i*OP_WIDTH +: OP_WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer with buffer and 2x2 MAC array models.
module tb_systolic_sequencer;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int KW = 4;
  localparam int LW = N * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done, rd_en, mac_clear, mac_ena;
  logic [KW-1:0] rd_addr;
  logic [LW-1:0] a_rd_data = '0;
  logic [LW-1:0] b_rd_data = '0;
  logic [LW-1:0] new_a_column, new_b_row;

  systolic_sequencer #(.N(N), .OP_WIDTH(W), .K_WIDTH(KW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .k_len        (k_len),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .a_rd_data    (a_rd_data),
    .b_rd_data    (b_rd_data),
    .mac_clear    (mac_clear),
    .mac_ena      (mac_ena),
    .new_a_column (new_a_column),
    .new_b_row    (new_b_row)
  );

  initial forever #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  // Operand buffers: one-cycle read latency, data holds when not reading.
  logic [LW-1:0] mem_a [16];
  logic [LW-1:0] mem_b [16];
  always @(posedge clk) begin
    if (rd_en) begin
      a_rd_data <= mem_a[rd_addr];
      b_rd_data <= mem_b[rd_addr];
    end
  end

  // Output-stationary array: A flows right along rows, B flows down columns.
  int acc [N][N];
  int ap  [N][N];
  int bp  [N][N];

  function automatic int lane(input logic [LW-1:0] v, input int i);
    return int'(v[i*W +: W]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        automatic int ain;
        automatic int bin;
        if (j == 0) ain = lane(new_a_column, i);
        else        ain = ap[i][j-1];
        if (i == 0) bin = lane(new_b_row, j);
        else        bin = bp[i-1][j];
        if (mac_clear) begin
          acc[i][j] <= 0;
          ap[i][j]  <= 0;
          bp[i][j]  <= 0;
        end else if (mac_ena) begin
          acc[i][j] <= acc[i][j] + ain * bin;
          ap[i][j]  <= ain;
          bp[i][j]  <= bin;
        end
      end
    end
  end

  typedef struct { int cyc; int c00; int c01; int c10; int c11; } done_exp_t;
  typedef struct { int cyc; int addr; } rd_exp_t;
  typedef struct { int cyc; int sel; logic [63:0] val; } probe_t;

  done_exp_t done_q  [$];
  rd_exp_t   rd_q    [$];
  int        clr_q   [$];
  probe_t    probe_q [$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cnt);
  endtask

  // Monitor: samples 1ns after each rising edge and retires expectations.
  initial begin : monitor
    done_exp_t d;
    rd_exp_t   r;
    probe_t    p;
    int        c;
    forever begin
      @(posedge clk);
      #1;
      if (mac_clear) begin
        if (clr_q.size() == 0) check("unexpected mac_clear", 1, 0);
        else begin
          c = clr_q.pop_front();
          check("mac_clear cycle", cnt, c);
        end
      end
      if (rd_en) begin
        if (rd_q.size() == 0) check("unexpected rd_en", 1, 0);
        else begin
          r = rd_q.pop_front();
          check("rd_en cycle", cnt, r.cyc);
          check("rd_addr", rd_addr, r.addr);
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected done", 1, 0);
        else begin
          d = done_q.pop_front();
          check("done cycle", cnt, d.cyc);
          check("C00", acc[0][0], d.c00);
          check("C01", acc[0][1], d.c01);
          check("C10", acc[1][0], d.c10);
          check("C11", acc[1][1], d.c11);
        end
      end
      while (probe_q.size() != 0 && probe_q[0].cyc <= cnt) begin
        p = probe_q.pop_front();
        case (p.sel)
          0: check($sformatf("busy @%0d", p.cyc), busy, p.val);
          1: check($sformatf("new_a_column @%0d", p.cyc), new_a_column, p.val);
          2: check($sformatf("new_b_row @%0d", p.cyc), new_b_row, p.val);
          default: check($sformatf("reset outputs @%0d", p.cyc),
                         {busy, done, rd_en, rd_addr, mac_clear, mac_ena,
                          new_a_column, new_b_row}, p.val);
        endcase
      end
    end
  end

  task automatic push_probe(input int cyc, input int sel, input logic [63:0] val);
    probe_t p;
    p.cyc = cyc; p.sel = sel; p.val = val;
    probe_q.push_back(p);
  endtask

  task automatic push_rd(input int cyc, input int addr);
    rd_exp_t r;
    r.cyc = cyc; r.addr = addr;
    rd_q.push_back(r);
  endtask

  // Expected response of a full pass whose start is sampled in cycle t0.
  task automatic expect_pass(input int t0, input int k,
                             input int c00, input int c01, input int c10, input int c11);
    done_exp_t d;
    clr_q.push_back(t0 + 1);
    for (int i = 0; i < k; i++) push_rd(t0 + 2 + i, i);
    d.cyc = (k == 0) ? t0 + 2 : t0 + k + 2 * N + 1;
    d.c00 = c00; d.c01 = c01; d.c10 = c10; d.c11 = c11;
    done_q.push_back(d);
  endtask

  task automatic issue_start(input int k);
    k_len = KW'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (done_q.size() == 0 && rd_q.size() == 0 && clr_q.size() == 0 &&
          probe_q.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard drained", done_q.size() + rd_q.size() + clr_q.size() + probe_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic load_basic();
    mem_a[0] = {8'd3, 8'd1};
    mem_a[1] = {8'd4, 8'd2};
    mem_b[0] = {8'd6, 8'd5};
    mem_b[1] = {8'd8, 8'd7};
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    logic [LW-1:0] exp_a [7];
    logic [LW-1:0] exp_b [7];

    // Reset values, during and just after reset.
    repeat (2) @(negedge clk);
    push_probe(cnt + 1, 3, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    push_probe(cnt + 1, 3, 64'd0);
    repeat (2) @(negedge clk);

    // Basic N=2, K=2.
    load_basic();
    t0 = cnt;
    expect_pass(t0, 2, 19, 22, 43, 50);
    push_probe(t0 + 1, 0, 1);
    push_probe(t0 + 7, 0, 1);
    push_probe(t0 + 8, 0, 0);
    issue_start(2);
    wait_drain();

    // Skew, K=3: A=[[1,2,3],[4,5,6]], B=[[1,0],[0,1],[1,1]].
    mem_a[0] = {8'd4, 8'd1}; mem_a[1] = {8'd5, 8'd2}; mem_a[2] = {8'd6, 8'd3};
    mem_b[0] = {8'd0, 8'd1}; mem_b[1] = {8'd1, 8'd0}; mem_b[2] = {8'd1, 8'd1};
    exp_a = '{16'h0000, 16'h0001, 16'h0402, 16'h0503, 16'h0600, 16'h0000, 16'h0000};
    exp_b = '{16'h0000, 16'h0001, 16'h0000, 16'h0101, 16'h0100, 16'h0000, 16'h0000};
    t0 = cnt;
    expect_pass(t0, 3, 4, 5, 10, 11);
    for (int c = 0; c < 7; c++) begin
      push_probe(t0 + 2 + c, 1, 64'(exp_a[c]));
      push_probe(t0 + 2 + c, 2, 64'(exp_b[c]));
    end
    issue_start(3);
    wait_drain();

    // K=0: clear then done, no reads.
    t0 = cnt;
    expect_pass(t0, 0, 0, 0, 0, 0);
    push_probe(t0 + 1, 0, 1);
    push_probe(t0 + 2, 0, 1);
    push_probe(t0 + 3, 0, 0);
    issue_start(0);
    wait_drain();

    // Start while busy is ignored; restart in the first IDLE cycle after DONE.
    load_basic();
    t0 = cnt;
    expect_pass(t0, 2, 19, 22, 43, 50);
    issue_start(2);
    while (cnt < t0 + 4) @(negedge clk);
    issue_start(2);
    while (cnt < t0 + 8) @(negedge clk);
    t0 = cnt;
    expect_pass(t0, 2, 19, 22, 43, 50);
    issue_start(2);
    wait_drain();

    // Reset mid-FEED of a K=4 pass: outputs return to reset values, no done.
    for (int k = 0; k < 4; k++) begin
      mem_a[k] = {8'd9, 8'd9};
      mem_b[k] = {8'd7, 8'd7};
    end
    t0 = cnt;
    clr_q.push_back(t0 + 1);
    push_rd(t0 + 2, 0);
    push_rd(t0 + 3, 1);
    for (int c = 4; c < 9; c++) push_probe(t0 + c, 3, 64'd0);
    issue_start(4);
    while (cnt < t0 + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_drain();

    load_basic();
    t0 = cnt;
    expect_pass(t0, 2, 19, 22, 43, 50);
    issue_start(2);
    wait_drain();

    // Max K=15 with all-ones operands.
    for (int k = 0; k < 16; k++) begin
      mem_a[k] = {8'd1, 8'd1};
      mem_b[k] = {8'd1, 8'd1};
    end
    t0 = cnt;
    expect_pass(t0, 15, 15, 15, 15, 15);
    push_probe(t0 + 20, 0, 1);
    push_probe(t0 + 21, 0, 0);
    issue_start(15);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Controller that runs one matrix-multiply pass on the N×N output-stationary MAC array. On `start` it clears the array accumulators and reads K operand vectors from the A-column and B-row buffers. It skews those vectors lane by lane into the array's `new_a_column`/`new_b_row` inputs, waits for the array to drain, then pulses `done` once every C accumulator holds its final dot product.

## Interface
Parameters:
- `N`, default 2: array dimension (lanes per operand vector).
- `OP_WIDTH`, default 8: operand width.
- `K_WIDTH`, default 8: width of inner-dimension length and buffer address.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a pass; sampled only in IDLE.
- `k_len`  in  K_WIDTH: inner dimension K; latched on accepted `start`.
- `busy`  out  1: high from the cycle after accepted `start` through the DONE cycle.
- `done`  out  1: one-cycle pulse; the C results are valid this cycle.
- `rd_en`  out  1: buffer read strobe (A and B buffers share it).
- `rd_addr`  out  K_WIDTH: vector index k.
- `a_rd_data`  in  N*OP_WIDTH: column k of A. Lane i is row i. Valid 1 cycle after `rd_en`.
- `b_rd_data`  in  N*OP_WIDTH: row k of B. Lane j is column j. Same latency as `a_rd_data`.
- `mac_clear`  out  1: one-cycle clear of all array accumulators.
- `mac_ena`  out  1: accumulate enable to the array.
- `new_a_column`  out  N*OP_WIDTH: skewed A lanes into the array.
- `new_b_row`  out  N*OP_WIDTH: skewed B lanes into the array.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `k_len` and moves to CLEAR.
  - `start` in any other state is ignored. It is not queued.
- CLEAR: 1 cycle. `mac_clear`=1. Next state is FEED, or DONE if K=0.
- FEED: K cycles.
  - In the k-th FEED cycle (k=0..K-1): `rd_en`=1 and `rd_addr`=k.
  - Leaves for DRAIN after k=K-1.
- DRAIN: exactly 2N-1 cycles, counted by a down-counter. `rd_en`=0. Next state is DONE.
- DONE: 1 cycle. `done`=1. Next state is IDLE.
- `mac_ena`=1 in FEED and DRAIN, 0 otherwise.
- Skew:
  - The data returned for index k is delayed i extra cycles on lane i (A) and lane j (B).
  - Lane i therefore presents element k in the cycle that is (k+1+i) cycles after FEED cycle 0.
  - A lane outputs 0 in any cycle where it holds no valid element. This covers fill, drain and idle. Zero operands add nothing to the accumulators.
- Width rules:
  - Operands pass through unmodified; the sequencer does no arithmetic on data.
  - The address counter is K_WIDTH bits and never wraps: the maximum K is 2^K_WIDTH − 1, and the last address is K−1.
- Reset at any time, including mid-FEED or mid-DRAIN:
  - Next state is IDLE and all skew registers are zeroed.
  - No `done` is generated for the aborted pass.
  - Array contents are undefined until the next CLEAR.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `mac_clear`=0, `mac_ena`=0, `new_a_column`=0, `new_b_row`=0.
- All outputs are registered or decoded from state registers. There is no combinational path from `start`.
- Cycle numbering: cycle 0 is the cycle `start` is sampled.
  - CLEAR: cycle 1.
  - FEED: cycles 2..K+1.
  - DRAIN: cycles K+2..K+2N.
  - DONE: cycle K+2N+1.
- Latency from `start` to `done` is K+2N+1 cycles. For K=0 it is 2 cycles.
- Back-to-back passes: `start` may be asserted in the first IDLE cycle after DONE. Minimum period is K+2N+2 cycles.
- Derivation of the drain length:
  - The last operand reaches PE(N−1,N−1) at cycle K+2N.
  - Its accumulate completes on that edge.
  - C is therefore valid during the DONE cycle.

## Structure
- Shared package `tpu_pkg`: the state enum `seq_state_t`, and the default constants for `OP_WIDTH` and `N`. The array's own instantiation uses the same package.
- One sub-module, `skew_line #(DEPTH, WIDTH)`: a DEPTH-stage shift register with a valid bit per stage and zero output when the slot is invalid. DEPTH=0 is a pass-through register.
- Instantiation: one `skew_line` per lane, generated for i=0..N−1 with DEPTH=i, for both A and B.
- FSM, address counter and drain counter live in the top level.

## Test plan
- **Basic, N=2, K=2:** A=[[1,2],[3,4]], B=[[5,6],[7,8]], `start` at cycle 0.
  - `mac_clear` at cycle 1.
  - `rd_addr` = 0, 1 at cycles 2, 3.
  - `done` at cycle 7 only.
  - The array model holds C=[[19,22],[43,50]].
- **Skew check, N=2, K=3:** lane 1 of `new_a_column` is 0 at cycle 3, A[1][0] at cycle 4, 0 again from cycle 7. Lane 0 is nonzero only in cycles 3..5.
- **K=0:** `start` gives `mac_clear` at cycle 1 and `done` at cycle 2. `rd_en` never asserts and `busy` is high for cycles 1..2.
- **Start while busy:** assert `start` again at cycle 4 of a K=2 pass. The pass still completes at cycle 7 and no second pass begins. A new `start` at cycle 8 runs normally.
- **Reset mid-FEED:** assert `reset` at cycle 3 of a K=4 pass. All outputs read their reset values from cycle 4 and `done` never pulses. A following pass with K=2 matches the basic-case results.
- **Max K:** with K_WIDTH=4 and K=15, `rd_addr` sweeps 0..14 without wrap and `done` arrives at cycle 20. Checked against a reference product of all-ones matrices: every C = 15.
